// File: rtl/dsp_cmd_sequencer_if.sv
// rtl/dsp_cmd_sequencer_if.sv - host command and dsp_core command port bundle
//
// Purpose: groups the host command handshake and the dsp_core command port
// of dsp_cmd_sequencer into one bundle.
//   slave  : the sequencer. It accepts host commands, drives the core command
//            strobes/targets and reports status.
//   master : the environment. It is the host/SPI decoder plus dsp_core, and
//            drives cmd_*, core_ready and reg_write_ack.
// Signals:
//   cmd_valid/cmd_ready, cmd_is_instr, cmd_block, cmd_reg, cmd_instr, cmd_val
//   core_ready, reg_write_ack
//   command_reg_write, command_instr_write, command_block_target,
//   command_reg_target, command_instr_write_val, command_reg_write_val
//   busy, fifo_count, err_timeout
// Register-address and instruction widths come from the dsp_core defines
// BLOCK_REG_ADDR_WIDTH / BLOCK_INSTR_WIDTH. Fallbacks are provided here.

`ifndef BLOCK_REG_ADDR_WIDTH
`define BLOCK_REG_ADDR_WIDTH 4
`endif
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

interface dsp_cmd_sequencer_if #(
  parameter int data_width = 16,
  parameter int n_blocks   = 256,
  parameter int fifo_depth = 8
);
  localparam int blk_w = $clog2(n_blocks);
  localparam int cnt_w = $clog2(fifo_depth) + 1;

  // host side
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic                            cmd_is_instr;
  logic [blk_w-1:0]                cmd_block;
  logic [`BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg;
  logic [`BLOCK_INSTR_WIDTH-1:0]   cmd_instr;
  logic [data_width-1:0]           cmd_val;

  // dsp_core side
  logic                                   core_ready;
  logic                                   command_reg_write;
  logic                                   command_instr_write;
  logic [blk_w-1:0]                       command_block_target;
  logic [blk_w+`BLOCK_REG_ADDR_WIDTH-1:0] command_reg_target;
  logic [`BLOCK_INSTR_WIDTH-1:0]          command_instr_write_val;
  logic [data_width-1:0]                  command_reg_write_val;
  logic                                   reg_write_ack;

  // status
  logic             busy;
  logic [cnt_w-1:0] fifo_count;
  logic             err_timeout;

  modport slave (
    input  cmd_valid, cmd_is_instr, cmd_block, cmd_reg, cmd_instr, cmd_val,
    input  core_ready, reg_write_ack,
    output cmd_ready,
    output command_reg_write, command_instr_write, command_block_target,
    output command_reg_target, command_instr_write_val, command_reg_write_val,
    output busy, fifo_count, err_timeout
  );

  modport master (
    output cmd_valid, cmd_is_instr, cmd_block, cmd_reg, cmd_instr, cmd_val,
    output core_ready, reg_write_ack,
    input  cmd_ready,
    input  command_reg_write, command_instr_write, command_block_target,
    input  command_reg_target, command_instr_write_val, command_reg_write_val,
    input  busy, fifo_count, err_timeout
  );
endinterface

// File: rtl/dsp_cmd_sequencer.sv
// rtl/dsp_cmd_sequencer.sv - serialises host reg/instr commands into the dsp_core command port
//
// Purpose: buffers host commands in a FIFO and issues them to dsp_core one at
// a time.
//   - Register writes hold command_reg_write high until reg_write_ack.
//   - Instruction writes pulse command_instr_write for one cycle once
//     core_ready is seen.
//   - Every command ends with a one-cycle gap with all strobes low, so the
//     core's edge detector always sees a fresh rising edge.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset. It abandons any in-flight
//            command and flushes the FIFO.
//   bus    : dsp_cmd_sequencer_if.slave. Carries the host command handshake,
//            the core command port and the status outputs
//            (busy, fifo_count, err_timeout).
// Optional feature macro: CMD_SEQ_TIMEOUT_EN.
//   Defined     : the ack wait gives up after timeout_cycles cycles. It sets
//                 the sticky err_timeout flag and moves on.
//   Not defined : the ack wait is unbounded and err_timeout is tied low.

`ifndef BLOCK_REG_ADDR_WIDTH
`define BLOCK_REG_ADDR_WIDTH 4
`endif
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

// Command FIFO.
//   - rdata always shows the head entry.
//   - The caller must not push while full or pop while empty.
module dsp_cmd_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [width-1:0]      wdata,
  output logic [width-1:0]      rdata,
  output logic [$clog2(depth):0] count,
  output logic                  full,
  output logic                  empty
);
  localparam int ptr_w = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (ptr_w + 1)'(depth));
  assign empty = (count == '0);

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module dsp_cmd_sequencer #(
  parameter int data_width     = 16,
  parameter int n_blocks       = 256,
  parameter int fifo_depth     = 8,
  parameter int timeout_cycles = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  dsp_cmd_sequencer_if.slave   bus
);
  localparam int blk_w = $clog2(n_blocks);
  localparam int reg_w = `BLOCK_REG_ADDR_WIDTH;
  localparam int ins_w = `BLOCK_INSTR_WIDTH;
  localparam int cnt_w = $clog2(fifo_depth) + 1;
  localparam int ent_w = 1 + blk_w + reg_w + ins_w + data_width;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INSTR_WAIT,
    REG_ASSERT,
    WAIT_ACK,
    GAP
  } state_t;

  state_t state;

  // FIFO plumbing
  logic [ent_w-1:0] fifo_wdata;
  logic [ent_w-1:0] fifo_rdata;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [cnt_w-1:0] fifo_cnt;

  logic                  h_is_instr;
  logic [blk_w-1:0]      h_block;
  logic [reg_w-1:0]      h_reg;
  logic [ins_w-1:0]      h_instr;
  logic [data_width-1:0] h_val;

  // Registered command-port outputs and the type of the in-flight command
  logic                  cur_is_instr;
  logic                  reg_write_q;
  logic                  instr_write_q;
  logic [blk_w-1:0]      block_q;
  logic [reg_w-1:0]      reg_q;
  logic [ins_w-1:0]      instr_q;
  logic [data_width-1:0] val_q;

  assign fifo_wdata = {bus.cmd_is_instr, bus.cmd_block, bus.cmd_reg, bus.cmd_instr, bus.cmd_val};
  assign fifo_push  = bus.cmd_valid && !fifo_full;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign {h_is_instr, h_block, h_reg, h_instr, h_val} = fifo_rdata;

  dsp_cmd_fifo #(
    .width (ent_w),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.cmd_ready               = !fifo_full;
  assign bus.command_reg_write       = reg_write_q;
  assign bus.command_instr_write     = instr_write_q;
  assign bus.command_block_target    = block_q;
  assign bus.command_reg_target      = {{blk_w{1'b0}}, reg_q};
  assign bus.command_instr_write_val = instr_q;
  assign bus.command_reg_write_val   = val_q;
  assign bus.busy                    = (state != IDLE) || !fifo_empty;
  assign bus.fifo_count              = fifo_cnt;

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam logic [15:0] tmo_last = 16'(timeout_cycles - 1);
  logic [15:0] tmo_cnt;
  logic        err_q;
  assign bus.err_timeout = err_q;
`else
  localparam int unused_timeout = timeout_cycles;
  assign bus.err_timeout = 1'b0;
`endif

  // Command FSM.
  // The strobes are registered, so the instruction pulse is launched one
  // cycle after core_ready is sampled. In the normal flow INSTR_WAIT is
  // therefore the cycle in which the pulse is high. core_ready is a level
  // from the core, so it is still valid when the pulse lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur_is_instr  <= 1'b0;
      reg_write_q   <= 1'b0;
      instr_write_q <= 1'b0;
      block_q       <= '0;
      reg_q         <= '0;
      instr_q       <= '0;
      val_q         <= '0;
`ifdef CMD_SEQ_TIMEOUT_EN
      tmo_cnt       <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            // Targets and values are frozen from here until the gap ends.
            cur_is_instr <= h_is_instr;
            block_q      <= h_block;
            reg_q        <= h_reg;
            instr_q      <= h_instr;
            val_q        <= h_val;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (cur_is_instr) begin
            instr_write_q <= bus.core_ready;
            state         <= INSTR_WAIT;
          end else begin
            reg_write_q <= 1'b1;
            state       <= REG_ASSERT;
          end
        end
        INSTR_WAIT: begin
          if (instr_write_q) begin
            instr_write_q <= 1'b0;
            state         <= GAP;
          end else if (bus.core_ready) begin
            instr_write_q <= 1'b1;
          end
        end
        REG_ASSERT: begin
          // A strobe-high cycle before acks are honoured, so a stale ack
          // cannot complete this write.
`ifdef CMD_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.reg_write_ack) begin
            reg_write_q <= 1'b0;
            state       <= GAP;
          end
`ifdef CMD_SEQ_TIMEOUT_EN
          else if (tmo_cnt == tmo_last) begin
            reg_write_q <= 1'b0;
            err_q       <= 1'b1;
            state       <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// tb/tb_dsp_cmd_sequencer.sv - directed self-checking bench for dsp_cmd_sequencer
`timescale 1ns/1ps

`ifndef BLOCK_REG_ADDR_WIDTH
`define BLOCK_REG_ADDR_WIDTH 4
`endif
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

module tb_dsp_cmd_sequencer;
  typedef struct {
    logic        is_instr;
    logic [7:0]  blk;
    logic [3:0]  rg;
    logic [31:0] instr;
    logic [15:0] val;
    logic [11:0] exp_tgt;
  } vec_t;

  typedef struct {
    logic        is_instr;
    logic [7:0]  blk;
    logic [11:0] tgt;
    logic [31:0] instr;
    logic [15:0] val;
  } rec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // core model / monitor state
  bit   ack_en;
  int   ack_lat;
  int   cd;
  int   acks;
  int   pulses;
  int   pulse_err;
  int   stab_err;
  int   hi_cnt;
  int   busy_cnt;
  int   log_n;
  bit   prev_rw;
  bit   prev_iw;
  bit   rise;
  rec_t cur;
  rec_t cap;
  rec_t log_mem [64];

  vec_t tbl [9];

  dsp_cmd_sequencer_if #(.data_width(16), .n_blocks(256), .fifo_depth(8)) bus ();

  dsp_cmd_sequencer #(
    .data_width     (16),
    .n_blocks       (256),
    .fifo_depth     (8),
    .timeout_cycles (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // dsp_core model: acks ack_lat cycles after each rising edge of
  // command_reg_write, and logs every write the core would perform.
  initial begin
    bus.reg_write_ack = 1'b0;
    cd = 0; acks = 0; pulses = 0; pulse_err = 0; stab_err = 0;
    hi_cnt = 0; busy_cnt = 0; log_n = 0; prev_rw = 0; prev_iw = 0;
    forever begin
      @(posedge clk); #2;
      bus.reg_write_ack = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          bus.reg_write_ack = 1'b1;
          acks = acks + 1;
        end
      end
      cur.is_instr = bus.command_instr_write;
      cur.blk      = bus.command_block_target;
      cur.tgt      = bus.command_reg_target;
      cur.instr    = bus.command_instr_write_val;
      cur.val      = bus.command_reg_write_val;
      rise = bus.command_reg_write && !prev_rw;
      if (rise) begin
        cap = cur;
        cap.is_instr = 1'b0;
        if (log_n < 64) log_mem[log_n] = cap;
        log_n = log_n + 1;
        if (ack_en) cd = ack_lat;
      end else if (bus.command_reg_write) begin
        if (cur.blk !== cap.blk || cur.tgt !== cap.tgt || cur.val !== cap.val)
          stab_err = stab_err + 1;
      end
      if (bus.command_instr_write) begin
        if (log_n < 64) log_mem[log_n] = cur;
        log_n  = log_n + 1;
        pulses = pulses + 1;
        if (prev_iw) pulse_err = pulse_err + 1;
      end
      if (bus.command_reg_write) hi_cnt = hi_cnt + 1;
      if (bus.busy) busy_cnt = busy_cnt + 1;
      prev_rw = bus.command_reg_write;
      prev_iw = bus.command_instr_write;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.cmd_is_instr = v.is_instr;
    bus.cmd_block    = v.blk;
    bus.cmd_reg      = v.rg;
    bus.cmd_instr    = v.instr;
    bus.cmd_val      = v.val;
    bus.cmd_valid    = 1'b1;
  endtask

  task automatic push(input vec_t v);
    drive(v);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!done) begin
      errors = errors + 1;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, max_cyc);
    end
  endtask

  initial begin
    int   base_log, base_acks, base_pulses, base_hi, base_busy;
    vec_t v;
    vec_t v2;
    checks = 0;
    errors = 0;

    tbl[0] = '{1'b1, 8'h10, 4'h0, 32'hA000_0001, 16'h0000, 12'h000};
    tbl[1] = '{1'b0, 8'h01, 4'h2, 32'h0000_0000, 16'h0102, 12'h002};
    tbl[2] = '{1'b1, 8'h22, 4'h0, 32'hB000_0002, 16'h0000, 12'h000};
    tbl[3] = '{1'b0, 8'hFF, 4'hF, 32'h0000_0000, 16'hFFFF, 12'h00F};
    tbl[4] = '{1'b0, 8'h00, 4'h0, 32'h0000_0000, 16'h0000, 12'h000};
    tbl[5] = '{1'b1, 8'h80, 4'h0, 32'hFFFF_FFFF, 16'h0000, 12'h000};
    tbl[6] = '{1'b0, 8'h33, 4'hA, 32'h0000_0000, 16'h8001, 12'h00A};
    tbl[7] = '{1'b1, 8'h44, 4'h0, 32'h0000_0000, 16'h0000, 12'h000};
    tbl[8] = '{1'b0, 8'h7E, 4'h5, 32'h0000_0000, 16'h5A5A, 12'h005};

    bus.cmd_valid = 1'b0; bus.cmd_is_instr = 1'b0; bus.cmd_block = '0;
    bus.cmd_reg = '0; bus.cmd_instr = '0; bus.cmd_val = '0; bus.core_ready = 1'b1;
    ack_en = 1'b1; ack_lat = 3;
    reset = 1'b1;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_strobes", {bus.command_reg_write, bus.command_instr_write}, 0);
    check("rst_targets", {bus.command_block_target, bus.command_reg_target}, 0);
    check("rst_values", {bus.command_instr_write_val, bus.command_reg_write_val}, 0);
    check("rst_err", bus.err_timeout, 0);
    tick();
    reset = 1'b0;
    tick();

    // reg write blk 5 reg 3, ack 3 cycles after the rise
    base_log = log_n; base_acks = acks; base_hi = hi_cnt; base_busy = busy_cnt;
    v = '{1'b0, 8'd5, 4'd3, 32'h0, 16'h1234, 12'h003};
    push(v);
    wait_idle("t2_idle", 40);
    check("t2_writes", log_n - base_log, 1);
    check("t2_record", {log_mem[base_log].is_instr, log_mem[base_log].blk,
                        log_mem[base_log].tgt, log_mem[base_log].val},
                       {1'b0, 8'd5, 12'h003, 16'h1234});
    check("t2_acks", acks - base_acks, 1);
    check("t2_strobe_cycles", hi_cnt - base_hi, 4);
    check("t2_busy_cycles", busy_cnt - base_busy, 7);
    check("t2_stable", stab_err, 0);

    // instr write held off by core_ready
    tick();
    bus.core_ready = 1'b0;
    base_pulses = pulses; base_log = log_n;
    v = '{1'b1, 8'd2, 4'd0, 32'hCAFE_BABE, 16'h0, 12'h000};
    push(v);
    repeat (10) tick();
    check("t3_no_pulse", pulses - base_pulses, 0);
    check("t3_busy_held", bus.busy, 1);
    bus.core_ready = 1'b1;
    wait_idle("t3_idle", 20);
    check("t3_one_pulse", pulses - base_pulses, 1);
    check("t3_record", {log_mem[base_log].is_instr, log_mem[base_log].blk, log_mem[base_log].instr},
                       {1'b1, 8'd2, 32'hCAFE_BABE});
    check("t3_pulse_width", pulse_err, 0);

    // fill the FIFO behind a stalled instr, then drain in order
    tick();
    bus.core_ready = 1'b0;
    ack_lat = 1;
    base_log = log_n;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      tick();
    end
    check("t4_full_count", bus.fifo_count, 8);
    check("t4_full_ready", bus.cmd_ready, 0);
    v = '{1'b0, 8'hEE, 4'hE, 32'hDEAD_BEEF, 16'hEEEE, 12'h00E};
    drive(v);
    tick();
    bus.cmd_valid = 1'b0;
    check("t4_push_when_full", bus.fifo_count, 8);
    bus.core_ready = 1'b1;
    wait_idle("t4_idle", 300);
    check("t4_writes", log_n - base_log, 9);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_instr)
        check($sformatf("t4_cmd%0d", i),
              {log_mem[base_log+i].is_instr, log_mem[base_log+i].blk, log_mem[base_log+i].instr},
              {1'b1, tbl[i].blk, tbl[i].instr});
      else
        check($sformatf("t4_cmd%0d", i),
              {log_mem[base_log+i].is_instr, log_mem[base_log+i].blk,
               log_mem[base_log+i].tgt, log_mem[base_log+i].val},
              {1'b0, tbl[i].blk, tbl[i].exp_tgt, tbl[i].val});
    end
    check("t4_drained", {bus.fifo_count, bus.cmd_ready}, {4'd0, 1'b1});

    // two reg writes to the same target
    tick();
    ack_lat = 2;
    base_log = log_n; base_acks = acks;
    v  = '{1'b0, 8'd7, 4'd9, 32'h0, 16'h00AA, 12'h009};
    v2 = '{1'b0, 8'd7, 4'd9, 32'h0, 16'h00BB, 12'h009};
    drive(v);
    tick();
    push(v2);
    wait_idle("t5_idle", 60);
    check("t5_rising_edges", log_n - base_log, 2);
    check("t5_acks", acks - base_acks, 2);
    check("t5_first", {log_mem[base_log].blk, log_mem[base_log].tgt, log_mem[base_log].val},
                      {8'd7, 12'h009, 16'h00AA});
    check("t5_second", {log_mem[base_log+1].blk, log_mem[base_log+1].tgt, log_mem[base_log+1].val},
                       {8'd7, 12'h009, 16'h00BB});

    // reset while waiting for an ack with 3 commands queued
    tick();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, 8'(i + 1), 4'(i), 32'h0, 16'(i), 12'(i)};
      drive(v);
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (8) tick();
    check("t1_pre_strobe", bus.command_reg_write, 1);
    check("t1_pre_count", bus.fifo_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t1_post_strobes", {bus.command_reg_write, bus.command_instr_write}, 0);
    check("t1_post_count", bus.fifo_count, 0);
    check("t1_post_ready_busy", {bus.cmd_ready, bus.busy}, 2'b10);
    tick();

`ifdef CMD_SEQ_TIMEOUT_EN
    // no ack: give up after 16 cycles, then the queued instr still issues
    base_log = log_n; base_hi = hi_cnt;
    v  = '{1'b0, 8'd1, 4'd1, 32'h0, 16'h5555, 12'h001};
    v2 = '{1'b1, 8'd3, 4'd0, 32'h1234_5678, 16'h0, 12'h000};
    drive(v);
    tick();
    push(v2);
    wait_idle("t6_idle", 100);
    check("t6_err", bus.err_timeout, 1);
    check("t6_strobe_cycles", hi_cnt - base_hi, 17);
    check("t6_strobe_low", bus.command_reg_write, 0);
    check("t6_writes", log_n - base_log, 2);
    check("t6_next_cmd", {log_mem[base_log+1].is_instr, log_mem[base_log+1].blk, log_mem[base_log+1].instr},
                         {1'b1, 8'd3, 32'h1234_5678});
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_err_cleared", bus.err_timeout, 0);
`else
    check("no_timeout_err", bus.err_timeout, 0);
`endif
    ack_en = 1'b1;

    check("final_stable", stab_err, 0);
    check("final_pulse_width", pulse_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
